// File: rtl/rx_filter_pkg.sv
// ---------------------------------------------------------------------------
// rx_filter_pkg
// Shared types, defaults and helpers for the multi-channel RX glitch filter.
//   filt_mode_t : per-strobe filter decision mode (hysteresis or majority)
//   DEF_*       : default parameter values used by the top level
//   popcount    : number of set bits in a zero-extended sample window
// ---------------------------------------------------------------------------
package rx_filter_pkg;

   typedef enum logic {
      FILT_HYST = 1'b0,
      FILT_MAJ  = 1'b1
   } filt_mode_t;

   localparam int   DEF_NCH         = 4;
   localparam int   DEF_SYNC_STAGES = 2;
   localparam int   DEF_DEPTH       = 3;
   localparam int   DEF_CW          = 8;
   localparam logic DEF_RESET_VAL   = 1'b1;

   // Windows are zero-extended to 32 bits by the caller, so counting every
   // bit gives the popcount of the real window.
   function automatic int popcount(input logic [31:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cnt += int'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rx_filter_chan.sv
// ---------------------------------------------------------------------------
// rx_filter_chan
// One independent filter channel: synchroniser chain, DEPTH-sample window,
// hysteresis/majority decision, registered edge pulses and a saturating
// rejected-glitch counter.
// Ports:
//   clk_i        system clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   sampleEn_i   sample strobe; window and output advance only when high
//   mode_i       decision mode for this strobe
//   cntClr_i     synchronous clear of the glitch counter (ignores strobe)
//   rxd_i        raw asynchronous input
//   rxd_o        filtered, registered output
//   rise_o       one-cycle pulse when rxd_o goes 0->1
//   fall_o       one-cycle pulse when rxd_o goes 1->0
//   glitchCnt_o  saturating count of rejected glitches
// ---------------------------------------------------------------------------
module rx_filter_chan
   import rx_filter_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   DEPTH       = DEF_DEPTH,
   parameter int   CW          = DEF_CW,
   parameter logic RESET_VAL   = DEF_RESET_VAL
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          sampleEn_i,
   input  filt_mode_t    mode_i,
   input  logic          cntClr_i,
   input  logic          rxd_i,
   output logic          rxd_o,
   output logic          rise_o,
   output logic          fall_o,
   output logic [CW-1:0] glitchCnt_o
);

   if (SYNC_STAGES < 2) begin : gSyncCheck
      $error("rx_filter_chan: SYNC_STAGES must be at least 2");
   end
   if (DEPTH < 2 || DEPTH > 32) begin : gDepthCheck
      $error("rx_filter_chan: DEPTH must be in the range 2..32");
   end

   localparam int HALF = DEPTH / 2;

   logic [SYNC_STAGES-1:0] syncChain_q;
   logic [DEPTH-1:0]       window_q, window_d;
   logic                   rxd_q, rxd_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic                   syncOut;
   logic [DEPTH-1:0]       windowNext;
   logic                   nextAllOnes, nextAllZeros, curUnanimous;
   logic                   majorityOne, decision, glitchEvent;

   assign syncOut = syncChain_q[SYNC_STAGES-1];

   // Synchroniser runs every clock so metastability settles regardless of
   // how sparse the sample strobe is.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         syncChain_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], rxd_i};
      end
   end

   // Decision logic works on the window as it will look after this strobe,
   // so the output reacts on the same edge the deciding sample enters.
   // A glitch is a disturbed window that settles back to the level already
   // being driven, i.e. a transition that never made it to the output.
   always_comb begin
      windowNext   = {window_q[DEPTH-2:0], syncOut};
      nextAllOnes  = &windowNext;
      nextAllZeros = ~|windowNext;
      curUnanimous = (&window_q) | (~|window_q);
      majorityOne  = popcount(32'(windowNext)) > HALF;

      decision = rxd_q;
      case (mode_i)
         FILT_MAJ:  decision = majorityOne;
         default: begin
            if (nextAllOnes)       decision = 1'b1;
            else if (nextAllZeros) decision = 1'b0;
         end
      endcase

      glitchEvent = !curUnanimous && (nextAllOnes || nextAllZeros)
                    && (windowNext[0] == rxd_q);

      window_d = window_q;
      rxd_d    = rxd_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (sampleEn_i) begin
         window_d = windowNext;
         rxd_d    = decision;
         rise_d   = decision & ~rxd_q;
         fall_d   = ~decision & rxd_q;
      end

      // Clear has priority over a simultaneous glitch and ignores the strobe.
      cnt_d = cnt_q;
      if (cntClr_i) begin
         cnt_d = '0;
      end else if (sampleEn_i && glitchEvent && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Window, output, pulse and counter registers; reset drops any partial
   // window without producing an edge pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         window_q <= {DEPTH{RESET_VAL}};
         rxd_q    <= RESET_VAL;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         window_q <= window_d;
         rxd_q    <= rxd_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rxd_o       = rxd_q;
   assign rise_o      = rise_q;
   assign fall_o      = fall_q;
   assign glitchCnt_o = cnt_q;

endmodule

// File: rtl/rx_glitch_filter.sv
// ---------------------------------------------------------------------------
// rx_glitch_filter
// NCH-channel RX input filter placed between the UART pads and the receiver
// FSMs. Each channel is an independent rx_filter_chan.
// Ports:
//   CLK         system clock
//   RST         synchronous active-high reset
//   SAMPLE_EN   sample strobe shared by all channels
//   MODE_SEL    0 = hysteresis, 1 = majority
//   CNT_CLR     synchronous clear of all glitch counters
//   RXD_IN      raw asynchronous inputs
//   RXD_OUT     filtered outputs
//   RISE/FALL   one-cycle edge pulses per channel
//   GLITCH_CNT  saturating glitch counts, channel i at [i*CW +: CW]
// ---------------------------------------------------------------------------
module rx_glitch_filter
   import rx_filter_pkg::*;
#(
   parameter int   NCH         = DEF_NCH,
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   DEPTH       = DEF_DEPTH,
   parameter int   CW          = DEF_CW,
   parameter logic RESET_VAL   = DEF_RESET_VAL,
   parameter bit   MAJ_ALLOWED = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SAMPLE_EN,
   input  logic              MODE_SEL,
   input  logic              CNT_CLR,
   input  logic [NCH-1:0]    RXD_IN,
   output logic [NCH-1:0]    RXD_OUT,
   output logic [NCH-1:0]    RISE,
   output logic [NCH-1:0]    FALL,
   output logic [NCH*CW-1:0] GLITCH_CNT
);

   // An even window has no strict majority, so majority mode needs odd DEPTH.
   if (MAJ_ALLOWED && (DEPTH % 2 == 0)) begin : gMajCheck
      $error("rx_glitch_filter: DEPTH must be odd when majority mode is allowed");
   end

   filt_mode_t modeSel;

   // Builds without majority support pin every channel to hysteresis.
   assign modeSel = (MAJ_ALLOWED && MODE_SEL) ? FILT_MAJ : FILT_HYST;

   for (genvar i = 0; i < NCH; i++) begin : gChan
      rx_filter_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEPTH       (DEPTH),
         .CW          (CW),
         .RESET_VAL   (RESET_VAL)
      ) uChan (
         .clk_i       (CLK),
         .rst_i       (RST),
         .sampleEn_i  (SAMPLE_EN),
         .mode_i      (modeSel),
         .cntClr_i    (CNT_CLR),
         .rxd_i       (RXD_IN[i]),
         .rxd_o       (RXD_OUT[i]),
         .rise_o      (RISE[i]),
         .fall_o      (FALL[i]),
         .glitchCnt_o (GLITCH_CNT[i*CW +: CW])
      );
   end

endmodule

// File: tb/tb_rx_glitch_filter.sv
// ---------------------------------------------------------------------------
// tb_rx_glitch_filter
// Directed vector table for reset/latency/glitch behaviour, hand-written
// sequences for majority, strobe gating and counter saturation/clear, then
// a random run checked against a behavioural model of all four channels.
// ---------------------------------------------------------------------------
module tb_rx_glitch_filter;

   logic        clk = 1'b0;
   logic        rst, sampleEn, modeSel, cntClr;
   logic [3:0]  rxdIn;
   logic [3:0]  rxdOut, rise, fall;
   logic [15:0] glitchCnt;

   int errors = 0;
   int checks = 0;

   rx_glitch_filter #(
      .NCH(4), .SYNC_STAGES(2), .DEPTH(3), .CW(4), .RESET_VAL(1'b1), .MAJ_ALLOWED(1'b1)
   ) dut (
      .CLK(clk), .RST(rst), .SAMPLE_EN(sampleEn), .MODE_SEL(modeSel), .CNT_CLR(cntClr),
      .RXD_IN(rxdIn), .RXD_OUT(rxdOut), .RISE(rise), .FALL(fall), .GLITCH_CNT(glitchCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] rxd;
      logic [3:0] expOut;
      logic [3:0] expRise;
      logic [3:0] expFall;
      logic [3:0] expCnt0;
      logic [3:0] expCnt1;
   } vec_t;

   vec_t vecs[33];

   // behavioural model state, index 2 of mWin is the newest sample
   bit mSync[4][2];
   bit mWin[4][3];
   bit mOut[4], mRise[4], mFall[4];
   int mCnt[4];

   function automatic vec_t mkVec(logic r, logic [3:0] x, logic [3:0] o, logic [3:0] ri,
                                  logic [3:0] fa, logic [3:0] c0, logic [3:0] c1);
      vec_t v;
      v.rst = r; v.rxd = x; v.expOut = o; v.expRise = ri; v.expFall = fa;
      v.expCnt0 = c0; v.expCnt1 = c1;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic s, input logic m,
                                input logic c, input logic [3:0] x);
      rst = r; sampleEn = s; modeSel = m; cntClr = c; rxdIn = x;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic glitchOnce();
      rxdIn = 4'hE;
      tick();
      rxdIn = 4'hF;
      repeat (5) tick();
   endtask

   task automatic modelStep(input bit r, input bit s, input bit m, input bit c, input logic [3:0] x);
      for (int ch = 0; ch < 4; ch++) begin
         if (r) begin
            mSync[ch][0] = 1; mSync[ch][1] = 1;
            for (int k = 0; k < 3; k++) mWin[ch][k] = 1;
            mOut[ch] = 1; mRise[ch] = 0; mFall[ch] = 0; mCnt[ch] = 0;
         end else begin
            bit sampled, newOut, beforeMixed, glitch;
            int onesBefore, onesAfter;
            sampled = mSync[ch][1];
            mSync[ch][1] = mSync[ch][0];
            mSync[ch][0] = x[ch];
            mRise[ch] = 0; mFall[ch] = 0;
            glitch = 0;
            if (s) begin
               onesBefore = mWin[ch][0] + mWin[ch][1] + mWin[ch][2];
               mWin[ch][0] = mWin[ch][1];
               mWin[ch][1] = mWin[ch][2];
               mWin[ch][2] = sampled;
               onesAfter = mWin[ch][0] + mWin[ch][1] + mWin[ch][2];
               beforeMixed = (onesBefore == 1) || (onesBefore == 2);
               if (m) newOut = (onesAfter >= 2);
               else if (onesAfter == 3) newOut = 1;
               else if (onesAfter == 0) newOut = 0;
               else newOut = mOut[ch];
               glitch = beforeMixed && ((onesAfter == 3 && mOut[ch]) || (onesAfter == 0 && !mOut[ch]));
               mRise[ch] = newOut && !mOut[ch];
               mFall[ch] = !newOut && mOut[ch];
               mOut[ch] = newOut;
            end
            if (c) mCnt[ch] = 0;
            else if (glitch && mCnt[ch] < 15) mCnt[ch]++;
         end
      end
   endtask

   function automatic logic [27:0] modelPacked();
      logic [27:0] p;
      p = '0;
      for (int ch = 0; ch < 4; ch++) begin
         p[ch]      = mOut[ch];
         p[4 + ch]  = mRise[ch];
         p[8 + ch]  = mFall[ch];
         p[12 + ch*4 +: 4] = 4'(mCnt[ch]);
      end
      return p;
   endfunction

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // reset, power-up fill, latency and hysteresis glitch (hyst mode, strobe every edge)
      vecs[0]  = mkVec(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[1]  = mkVec(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[2]  = mkVec(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[3]  = mkVec(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[4]  = mkVec(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[5]  = mkVec(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[6]  = mkVec(0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0);
      vecs[7]  = mkVec(0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0);
      vecs[8]  = mkVec(0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0);
      vecs[9]  = mkVec(0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0);
      vecs[10] = mkVec(0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0);
      vecs[11] = mkVec(0, 4'hF, 4'hF, 4'hF, 4'h0, 0, 0);
      vecs[12] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[13] = mkVec(0, 4'hE, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[14] = mkVec(0, 4'hE, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[15] = mkVec(0, 4'hE, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[16] = mkVec(0, 4'hE, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[17] = mkVec(0, 4'hE, 4'hE, 4'h0, 4'h1, 0, 0);
      vecs[18] = mkVec(0, 4'hE, 4'hE, 4'h0, 4'h0, 0, 0);
      vecs[19] = mkVec(0, 4'hF, 4'hE, 4'h0, 4'h0, 0, 0);
      vecs[20] = mkVec(0, 4'hF, 4'hE, 4'h0, 4'h0, 0, 0);
      vecs[21] = mkVec(0, 4'hF, 4'hE, 4'h0, 4'h0, 0, 0);
      vecs[22] = mkVec(0, 4'hF, 4'hE, 4'h0, 4'h0, 0, 0);
      vecs[23] = mkVec(0, 4'hF, 4'hF, 4'h1, 4'h0, 0, 0);
      vecs[24] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[25] = mkVec(0, 4'hE, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[26] = mkVec(0, 4'hE, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[27] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[28] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[29] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[30] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0);
      vecs[31] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 0);
      vecs[32] = mkVec(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 0);

      applyStimulus(1, 0, 0, 0, 4'h0);
      #2;
      for (int i = 0; i < 33; i++) begin
         applyStimulus(vecs[i].rst, 1, 0, 0, vecs[i].rxd);
         tick();
         checkOutput($sformatf("vec%0d out", i),  32'(rxdOut), 32'(vecs[i].expOut));
         checkOutput($sformatf("vec%0d rise", i), 32'(rise), 32'(vecs[i].expRise));
         checkOutput($sformatf("vec%0d fall", i), 32'(fall), 32'(vecs[i].expFall));
         checkOutput($sformatf("vec%0d cnt0", i), 32'(glitchCnt[3:0]), 32'(vecs[i].expCnt0));
         checkOutput($sformatf("vec%0d cnt1", i), 32'(glitchCnt[7:4]), 32'(vecs[i].expCnt1));
      end

      // majority: a 1-sample dip is outvoted, a 2-sample dip wins for a while
      applyStimulus(0, 1, 1, 0, 4'hF);
      tick();
      checkOutput("maj switch out", 32'(rxdOut), 32'hF);
      rxdIn = 4'hE;
      tick();
      rxdIn = 4'hF;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput($sformatf("maj pulse1 out0 e%0d", k), 32'(rxdOut[0]), 32'd1);
         checkOutput($sformatf("maj pulse1 fall0 e%0d", k), 32'(fall[0]), 32'd0);
      end
      checkOutput("maj pulse1 cnt0", 32'(glitchCnt[3:0]), 32'd2);
      rxdIn = 4'hE;
      tick();
      tick();
      rxdIn = 4'hF;
      tick();
      checkOutput("maj pulse2 out0 b+2", 32'(rxdOut[0]), 32'd1);
      tick();
      checkOutput("maj pulse2 out0 b+3", 32'(rxdOut[0]), 32'd0);
      checkOutput("maj pulse2 fall0 b+3", 32'(fall[0]), 32'd1);
      tick();
      checkOutput("maj pulse2 out0 b+4", 32'(rxdOut[0]), 32'd0);
      checkOutput("maj pulse2 fall0 b+4", 32'(fall[0]), 32'd0);
      tick();
      checkOutput("maj pulse2 out0 b+5", 32'(rxdOut[0]), 32'd1);
      checkOutput("maj pulse2 rise0 b+5", 32'(rise[0]), 32'd1);
      tick();
      checkOutput("maj pulse2 rise0 b+6", 32'(rise[0]), 32'd0);
      checkOutput("maj pulse2 cnt0", 32'(glitchCnt[3:0]), 32'd3);
      checkOutput("maj others out", 32'(rxdOut[3:1]), 32'h7);

      // strobe every 4th clock: 8-clock dip reaches only two strobes
      modeSel = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         rxdIn = (k <= 8) ? 4'hE : 4'hF;
         sampleEn = (k % 4 == 0);
         tick();
         checkOutput($sformatf("gate8 out0 e%0d", k), 32'(rxdOut[0]), 32'd1);
      end
      checkOutput("gate8 cnt0", 32'(glitchCnt[3:0]), 32'd4);
      // 16-clock dip: output falls on the third strobe carrying the low level
      for (int k = 1; k <= 28; k++) begin
         rxdIn = (k <= 16) ? 4'hE : 4'hF;
         sampleEn = (k % 4 == 0);
         tick();
         checkOutput($sformatf("gate16 out0 e%0d", k), 32'(rxdOut[0]),
                     (k >= 12 && k < 28) ? 32'd0 : 32'd1);
         checkOutput($sformatf("gate16 fall0 e%0d", k), 32'(fall[0]), (k == 12) ? 32'd1 : 32'd0);
         checkOutput($sformatf("gate16 rise0 e%0d", k), 32'(rise[0]), (k == 28) ? 32'd1 : 32'd0);
      end
      checkOutput("gate16 cnt0", 32'(glitchCnt[3:0]), 32'd4);

      // counter saturation and clear priority
      sampleEn = 1'b1;
      repeat (20) glitchOnce();
      checkOutput("sat cnt0", 32'(glitchCnt[3:0]), 32'd15);
      checkOutput("sat cnt1", 32'(glitchCnt[7:4]), 32'd0);
      rxdIn = 4'hE;
      tick();
      rxdIn = 4'hF;
      repeat (4) tick();
      checkOutput("pre-clr cnt0", 32'(glitchCnt[3:0]), 32'd15);
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
      checkOutput("clr vs glitch cnt0", 32'(glitchCnt[3:0]), 32'd0);
      glitchOnce();
      checkOutput("post-clr cnt0", 32'(glitchCnt[3:0]), 32'd1);

      // reset with a partially filled window: no pulse, counters cleared
      rxdIn = 4'hE;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rxdIn = 4'hF;
      checkOutput("midrst out", 32'(rxdOut), 32'hF);
      checkOutput("midrst fall", 32'(fall), 32'h0);
      checkOutput("midrst cnt0", 32'(glitchCnt[3:0]), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput($sformatf("midrst after out e%0d", k), 32'(rxdOut), 32'hF);
         checkOutput($sformatf("midrst after fall e%0d", k), 32'(fall), 32'h0);
      end

      // clear while the strobe is low
      glitchOnce();
      checkOutput("pre-clr2 cnt0", 32'(glitchCnt[3:0]), 32'd1);
      sampleEn = 1'b0;
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
      sampleEn = 1'b1;
      checkOutput("clr no strobe cnt0", 32'(glitchCnt[3:0]), 32'd0);

      // random run against the behavioural model
      applyStimulus(1, 1, 0, 0, 4'hF);
      modelStep(1, 1, 0, 0, 4'hF);
      tick();
      checkOutput("rand reset", {rise, fall, rxdOut} == 12'h00F ? 32'(glitchCnt) : 32'hDEAD, 32'h0);
      for (int cyc = 0; cyc < 10000; cyc++) begin
         logic [3:0] x;
         logic       m;
         x = rxdIn;
         for (int ch = 0; ch < 4; ch++) begin
            if ($urandom_range(0, 5) == 0) x[ch] = ~x[ch];
         end
         m = modeSel;
         if ($urandom_range(0, 49) == 0) m = ~m;
         applyStimulus(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), m,
                       ($urandom_range(0, 99) == 0), x);
         modelStep(rst, sampleEn, modeSel, cntClr, rxdIn);
         tick();
         checkOutput($sformatf("scoreboard cyc%0d", cyc),
                     32'({glitchCnt, fall, rise, rxdOut}), 32'(modelPacked()));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
